// File: rtl/uart_rx_datapath.sv
// UART receiver datapath: line synchroniser, start-bit detection, bit-centre timing,
// byte assembly under rx_controller commands, and the processor-side output register.
module uart_rx_datapath #(
  parameter int unsigned BAUD_DIV  = 868,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 bit_clr,
  input  logic                 take_value,
  input  logic                 incre_counter,
  input  logic                 get_output,
  output logic                 start_bit,
  output logic                 get_value,
  output logic                 data_received,
  output logic                 stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err
);

  localparam int unsigned HALF = BAUD_DIV / 2;
  localparam int unsigned LW   = $clog2(HALF + 1);
  localparam int unsigned BW   = $clog2(BAUD_DIV);
  localparam int unsigned TW   = $clog2(DATA_BITS + 2);
  localparam int unsigned CW   = $clog2(DATA_BITS + 1);

  localparam logic [LW-1:0] HalfCnt  = LW'(HALF);
  localparam logic [BW-1:0] BaudLast = BW'(BAUD_DIV - 1);
  // tick_idx holds (tick number - 1), so the stop tick sees tick_idx == DATA_BITS
  localparam logic [TW-1:0] StopIdx  = TW'(DATA_BITS);
  localparam logic [CW-1:0] CntFull  = CW'(DATA_BITS);

  logic                 sync1;
  logic                 rx_s;
  logic                 busy;
  logic                 armed;
  logic                 sample_bit;
  logic                 tick;
  logic [LW-1:0]        low_cnt;
  logic [BW-1:0]        baud_cnt;
  logic [TW-1:0]        tick_idx;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  always_comb begin
    tick          = busy && (baud_cnt == BaudLast);
    start_bit     = !busy && armed && (low_cnt == HalfCnt);
    get_value     = tick && (tick_idx < StopIdx);
    stop          = tick && (tick_idx == StopIdx);
    data_received = (bit_cnt == CntFull);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      armed      <= 1'b0;
      low_cnt    <= '0;
      baud_cnt   <= '0;
      tick_idx   <= '0;
      sample_bit <= 1'b0;
    end else begin
      // A line that has not been seen high since the last frame cannot start a new one
      if (stop) begin
        busy  <= 1'b0;
        armed <= 1'b0;
      end else if (!busy && rx_s) begin
        armed <= 1'b1;
      end

      if (busy) begin
        low_cnt <= '0;
        if (tick) begin
          baud_cnt <= '0;
          tick_idx <= tick_idx + TW'(1);
        end else begin
          baud_cnt <= baud_cnt + BW'(1);
        end
        if (get_value) sample_bit <= rx_s;
      end else if (start_bit) begin
        busy     <= 1'b1;
        baud_cnt <= '0;
        tick_idx <= '0;
        low_cnt  <= '0;
      end else if (armed && !rx_s) begin
        low_cnt <= low_cnt + LW'(1);
      end else begin
        low_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (incre_counter && (bit_cnt != CntFull)) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (take_value) shift_reg <= {sample_bit, shift_reg[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= stop && get_output;
      if (stop && get_output) begin
        rx_data   <= shift_reg;
        frame_err <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Bench for uart_rx_datapath: a simple command sequencer stands in for rx_controller and a
// cycle-level behavioural model plus frame scoreboard check the outputs.
module tb_uart_rx_datapath;

  localparam int BAUD = 16;
  localparam int DB   = 8;
  localparam int HALF = BAUD / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_in = 1'b1;
  logic       bit_clr = 1'b0;
  logic       take_value = 1'b0;
  logic       incre_counter = 1'b0;
  logic       get_output = 1'b0;
  logic       start_bit, get_value, data_received, stop, rx_valid, frame_err;
  logic [7:0] rx_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;

  uart_rx_datapath #(.BAUD_DIV(BAUD), .DATA_BITS(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .bit_clr       (bit_clr),
    .take_value    (take_value),
    .incre_counter (incre_counter),
    .get_output    (get_output),
    .start_bit     (start_bit),
    .get_value     (get_value),
    .data_received (data_received),
    .stop          (stop),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Controller stand-in: reacts one cycle after each pulse, like a registered FSM
  logic ctl_hold = 1'b0;
  int   ccnt = 0;
  logic c_sv, c_gv;
  initial begin
    forever begin
      @(negedge clk);
      c_sv = start_bit;
      c_gv = get_value;
      @(posedge clk);
      #1;
      if (!reset) begin
        ccnt = 0;
        bit_clr = 0; take_value = 0; incre_counter = 0; get_output = 0;
      end else begin
        bit_clr       = c_sv;
        take_value    = c_gv;
        incre_counter = c_gv;
        if (c_sv) ccnt = 0;
        else if (c_gv) ccnt++;
        get_output = (ccnt == DB) && !ctl_hold;
      end
    end
  end

  // Behavioural model: frame timing from the start-bit cycle by arithmetic
  logic       h1 = 1'b1, h2 = 1'b1;
  logic       m_armed, m_busy, m_sample, m_valid, m_ferr;
  logic [7:0] m_sr, m_data;
  int         m_run, m_start, m_cnt;
  logic       rs, e_start, e_gv, e_stop;
  int         d, k;
  int         n_start = 0;
  int         last_start = 0;
  int         gv_q[$];
  logic [8:0] obs_q[$];

  task automatic model_reset();
    m_armed = 0; m_busy = 0; m_sample = 0; m_valid = 0; m_ferr = 0;
    m_sr = 0; m_data = 0; m_run = -1; m_start = 0; m_cnt = 0;
    h1 = 1; h2 = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("reset_outputs", {18'd0, start_bit, get_value, stop, data_received, rx_valid,
                                frame_err, rx_data}, 32'd0);
        model_reset();
      end else begin
        rs      = h2;
        e_start = !m_busy && m_armed && (m_run >= 0) && ((cyc - m_run) == HALF);
        e_gv    = 0;
        e_stop  = 0;
        if (m_busy) begin
          d = cyc - m_start;
          if (d % BAUD == 0) begin
            k      = d / BAUD;
            e_gv   = (k >= 1) && (k <= DB);
            e_stop = (k == DB + 1);
          end
        end
        check("start_bit", start_bit, e_start);
        check("get_value", get_value, e_gv);
        check("stop", stop, e_stop);
        check("data_received", data_received, m_cnt == DB);
        check("rx_valid", rx_valid, m_valid);
        check("rx_data", rx_data, m_data);
        check("frame_err", frame_err, m_ferr);

        if (start_bit === 1'b1) begin n_start++; last_start = cyc; end
        if (get_value === 1'b1) gv_q.push_back(cyc);
        if (rx_valid === 1'b1) obs_q.push_back({frame_err, rx_data});

        m_valid = 0;
        if (e_stop && get_output) begin
          m_valid = 1; m_data = m_sr; m_ferr = !rs;
        end
        if (take_value) m_sr = {m_sample, m_sr[7:1]};
        if (e_gv) m_sample = rs;
        if (bit_clr) m_cnt = 0;
        else if (incre_counter && m_cnt < DB) m_cnt++;

        if (e_stop) begin
          m_busy = 0; m_armed = 0;
        end else if (e_start) begin
          m_busy = 1; m_start = cyc; m_run = -1;
        end else if (!m_busy) begin
          if (rs) begin
            m_armed = 1; m_run = -1;
          end else if (m_armed && m_run < 0) begin
            m_run = cyc;
          end
        end
        h2 = h1;
        h1 = rx_in;
      end
    end
  end

  int last_fall = 0;

  task automatic drive(input logic v, input int n);
    rx_in = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sb);
    last_fall = cyc;
    drive(1'b0, BAUD);
    for (int i = 0; i < DB; i++) drive(b[i], BAUD);
    drive(sb, BAUD);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int         n0;
  logic [7:0] sb_q[$];
  logic       se_q[$];
  logic [7:0] rb;
  logic       rgood;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1;

    // 1: idle after reset
    drive(1'b1, 50);
    check("t1_no_start", n_start, 0);
    check("t1_no_valid", obs_q.size(), 0);
    check("t1_rx_data", rx_data, 0);

    // 2: 0xA5, good stop
    gv_q.delete();
    send_byte(8'hA5, 1'b1);
    drive(1'b1, 30);
    check("t2_start_latency", last_start - last_fall, 2 + HALF);
    check("t2_get_value_count", gv_q.size(), DB);
    if (gv_q.size() == DB) begin
      check("t2_first_centre", gv_q[0] - last_start, BAUD);
      for (int i = 0; i < DB - 1; i++) check("t2_spacing", gv_q[i+1] - gv_q[i], BAUD);
    end
    check("t2_valid_count", obs_q.size(), 1);
    if (obs_q.size() == 1) check("t2_byte", obs_q[0], {1'b0, 8'hA5});

    // 3: short glitch
    obs_q.delete(); gv_q.delete(); n0 = n_start;
    drive(1'b0, 5);
    drive(1'b1, 40);
    check("t3_no_start", n_start - n0, 0);
    check("t3_no_get_value", gv_q.size(), 0);
    check("t3_no_valid", obs_q.size(), 0);

    // 4: 0x3C with low stop, then a break
    n0 = n_start;
    send_byte(8'h3C, 1'b0);
    drive(1'b0, 3 * 10 * BAUD);
    check("t4_valid_count", obs_q.size(), 1);
    if (obs_q.size() == 1) check("t4_byte", obs_q[0], {1'b1, 8'h3C});
    check("t4_single_start", n_start - n0, 1);
    drive(1'b1, 40);
    check("t4_no_restart", n_start - n0, 1);

    // 5: reset during 0xFF, then 0x81
    obs_q.delete();
    drive(1'b0, BAUD);
    for (int i = 0; i < 4; i++) drive(1'b1, BAUD);
    drive(1'b1, HALF);
    reset = 0;
    rx_in = 1;
    #1;
    check("t5_rx_data_in_reset", rx_data, 0);
    check("t5_frame_err_in_reset", frame_err, 0);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1;
    drive(1'b1, 30);
    send_byte(8'h81, 1'b1);
    drive(1'b1, 30);
    check("t5_valid_count", obs_q.size(), 1);
    if (obs_q.size() == 1) check("t5_byte", obs_q[0], {1'b0, 8'h81});

    // 6: back-to-back frames
    obs_q.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    drive(1'b1, 30);
    check("t6_valid_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("t6_byte0", obs_q[0], {1'b0, 8'h00});
      check("t6_byte1", obs_q[1], {1'b0, 8'hFF});
    end

    // stop arriving while the controller withholds get_output
    obs_q.delete();
    ctl_hold = 1;
    send_byte(8'h55, 1'b1);
    drive(1'b1, 20);
    ctl_hold = 0;
    drive(1'b1, 10);
    check("t6b_no_load", obs_q.size(), 0);
    check("t6b_rx_data_held", rx_data, 8'hFF);

    // 7: random frames, gaps and glitches against a frame scoreboard
    obs_q.delete();
    for (int f = 0; f < 25; f++) begin
      rb    = 8'($urandom_range(0, 255));
      rgood = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, $urandom_range(1, HALF - 1));
        drive(1'b1, $urandom_range(3, 10));
      end
      sb_q.push_back(rb);
      se_q.push_back(!rgood);
      send_byte(rb, rgood);
      drive(1'b1, rgood ? $urandom_range(0, 20) : $urandom_range(1, 20));
    end
    drive(1'b1, 30);
    check("t7_valid_count", obs_q.size(), sb_q.size());
    for (int i = 0; i < sb_q.size() && i < obs_q.size(); i++)
      check("t7_frame", obs_q[i], {se_q[i], sb_q[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
